wb_fifo_slave: RTL and testbench
================================

WB_FIFO_SLAVE -- requirements
Module: wb_fifo_slave

Interface
REQ-001 Parameter DATA_WIDTH, 32, data bus width in bits.
REQ-002 Parameter ADDR_WIDTH, 16, address bus width in bits.
REQ-003 Parameter DEPTH, 16, FIFO entries; SHALL be a power of two, at least 2.
REQ-004 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous and active-high.
REQ-006 cyc_i  in  1  bus cycle valid, from the bus cyc output shared by all slaves.
REQ-007 stb_i  in  1  per-slave strobe from the bus.
REQ-008 we_i  in  1  1 = write, 0 = read.
REQ-009 adr_i  in  ADDR_WIDTH  byte address; only adr_i[3:0] is decoded.
REQ-010 dat_i  in  DATA_WIDTH  write data.
REQ-011 sel_i  in  4  byte selects.
REQ-012 dat_o  out  DATA_WIDTH  read data, valid only while ack_o=1.
REQ-013 ack_o  out  1  normal termination pulse.
REQ-014 err_o  out  1  error termination pulse.

Function
REQ-015 Register map (adr_i[3:0]):
- 0x0 DATA: write pushes dat_i; read pops the head.
- 0x4 STATUS (RO): [0] empty, [1] full, [2] sticky overflow, [3] sticky underflow, [15:8] count; other bits 0.
- 0x8 CTRL (WO): [0] flush, [1] clear sticky flags; reads return 0.
- 0xC, or adr_i[1:0]!=0: error.
REQ-016 FSM states:
- IDLE: on cyc_i&stb_i, go to RESP and register the response.
- RESP: return to IDLE unconditionally.
REQ-017 Latency is exactly 1 cycle: ack_o or err_o is high in the cycle after the request is sampled in IDLE, for exactly one cycle.
REQ-018 ack_o and err_o SHALL never be high together.
REQ-019 A request still held during RESP SHALL NOT be sampled again; a held strobe therefore gets one response every 2 cycles.
REQ-020 Side effects (push, pop, flush, clear) occur only on the IDLE->RESP edge, at most once per response.
REQ-021 Any of the following SHALL give err_o, with no state change:
- write to DATA with sel_i!=4'hF;
- write to STATUS;
- an address error per REQ-015.
REQ-022 Write to DATA when full: err_o, no push, overflow flag set.
REQ-023 Read from DATA when empty: err_o, dat_o=0, underflow flag set.
REQ-024 dat_o SHALL be 0 whenever ack_o=0.
REQ-025 Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits wide, range 0..DEPTH.
REQ-026 Flush sets count=0 and both pointers to 0, and leaves the sticky flags unchanged.
REQ-027 CTRL write with both bits set performs flush and clear in the same cycle.
REQ-028 Requests with cyc_i=0 SHALL be ignored whatever stb_i is.

Reset
REQ-029 While rst_i=1, regardless of clk_i:
- FSM in IDLE;
- ack_o=0, err_o=0, dat_o=0;
- pointers and count 0; sticky flags 0.
REQ-030 Reset asserted during RESP SHALL drop the response in the same cycle; a sampled push or pop is lost.
REQ-031 FIFO storage contents need not be reset.

Structure
REQ-032 Shared package wb_pkg holds ADDR_WIDTH, DATA_WIDTH, the register offset constants and the FSM state enum.
REQ-033 Storage, pointers and count sit in one sub-module, wb_sync_fifo (push, pop, flush, wdata, rdata, full, empty, count); wb_fifo_slave holds the decode, FSM and sticky flags.

Verification
REQ-034 Write 0xA5A5_0001 then 0xA5A5_0002 to 0x0, then read 0x0 twice -> two acks returning 0xA5A5_0001 then 0xA5A5_0002; STATUS then reads 0x0000_0001.
REQ-035 DEPTH=16: 16 writes, a 17th write, then read STATUS -> 16 acks; 17th gives err_o; STATUS=0x0000_1006.
REQ-036 Read 0x0 when empty -> err_o with dat_o=0; STATUS=0x0000_0009; write 0x2 to 0x8 -> STATUS=0x0000_0001.
REQ-037 Wrap-around: 24 push/pop pairs with data 0..23 -> each read returns the value just written; count 0 at end.
REQ-038 Push 3 words, write 0x1 to 0x8 -> STATUS=0x0000_0001; access to 0xC, 0x2, and a DATA write with sel_i=4'h3 -> err_o each, count unchanged.
REQ-039 Hold stb_i for 6 cycles on a DATA write -> exactly 3 ack pulses, 3 pushes; rst_i pulsed in a RESP cycle -> ack_o falls immediately and count=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone FIFO slave: bus widths, register
// offsets and the bus-response FSM state type.
package wb_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 16;

  // Register offsets, decoded from adr_i[3:0]
  localparam logic [3:0] ADR_DATA   = 4'h0;
  localparam logic [3:0] ADR_STATUS = 4'h4;
  localparam logic [3:0] ADR_CTRL   = 4'h8;

  // STATUS bit positions
  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_OVF_BIT   = 2;
  localparam int ST_UNF_BIT   = 3;
  localparam int ST_COUNT_LSB = 8;

  // CTRL bit positions
  localparam int CTRL_FLUSH_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers and occupancy count.
// Push while full and pop while empty are ignored; flush wins over both.
module wb_sync_fifo import wb_pkg::*; #(
  parameter int DATA_WIDTH = wb_pkg::DATA_WIDTH,
  parameter int DEPTH      = 16,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  // Storage write; contents are not reset, only pointers/count are.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointer and count update; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_fifo_slave.sv
// Wishbone classic slave in front of a FIFO: DATA push/pop, STATUS and CTRL
// registers, sticky overflow/underflow flags.
//
// Handshake: a request is cyc_i & stb_i sampled while the FSM is IDLE. The
// reply is exactly one cycle of ack_o or err_o in the following (RESP) cycle;
// a request still held during RESP is not sampled again, so a held strobe is
// answered every second cycle. All side effects happen on the sampling edge.
module wb_fifo_slave import wb_pkg::*; #(
  parameter int DATA_WIDTH = wb_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = wb_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic [3:0]            sel_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  dbg_state
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_state_e             state;
  logic                  ovf_flag;
  logic                  unf_flag;

  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  logic                  req;
  logic [3:0]            off;
  logic [DATA_WIDTH-1:0] status_word;

  logic                  d_ack;
  logic                  d_err;
  logic [DATA_WIDTH-1:0] d_dat;
  logic                  d_push;
  logic                  d_pop;
  logic                  d_flush;
  logic                  d_clear;
  logic                  d_ovf;
  logic                  d_unf;

  logic                  unused_bits;

  assign unused_bits = ^{adr_i[ADDR_WIDTH-1:4], dat_i[DATA_WIDTH-1:2]};
  assign dbg_state   = state;
  assign req         = cyc_i & stb_i & (state == ST_IDLE);
  assign off         = adr_i[3:0];

  // STATUS register image
  always_comb begin
    status_word                          = '0;
    status_word[ST_EMPTY_BIT]            = fifo_empty;
    status_word[ST_FULL_BIT]             = fifo_full;
    status_word[ST_OVF_BIT]              = ovf_flag;
    status_word[ST_UNF_BIT]              = unf_flag;
    status_word[ST_COUNT_LSB +: CNT_W]   = fifo_count;
  end

  // Address/command decode into the response and side effects of a request
  always_comb begin
    d_ack   = 1'b0;
    d_err   = 1'b0;
    d_dat   = '0;
    d_push  = 1'b0;
    d_pop   = 1'b0;
    d_flush = 1'b0;
    d_clear = 1'b0;
    d_ovf   = 1'b0;
    d_unf   = 1'b0;
    if (off[1:0] != 2'b00) begin
      d_err = 1'b1;
    end else begin
      case (off)
        ADR_DATA: begin
          if (we_i) begin
            if (sel_i != 4'hF) begin
              d_err = 1'b1;
            end else if (fifo_full) begin
              d_err = 1'b1;
              d_ovf = 1'b1;
            end else begin
              d_ack  = 1'b1;
              d_push = 1'b1;
            end
          end else begin
            if (fifo_empty) begin
              d_err = 1'b1;
              d_unf = 1'b1;
            end else begin
              d_ack = 1'b1;
              d_pop = 1'b1;
              d_dat = fifo_rdata;
            end
          end
        end
        ADR_STATUS: begin
          if (we_i) begin
            d_err = 1'b1;
          end else begin
            d_ack = 1'b1;
            d_dat = status_word;
          end
        end
        ADR_CTRL: begin
          d_ack = 1'b1;
          if (we_i) begin
            d_flush = dat_i[CTRL_FLUSH_BIT];
            d_clear = dat_i[CTRL_CLEAR_BIT];
          end
        end
        default: d_err = 1'b1;
      endcase
    end
  end

  // Bus FSM with registered response and sticky flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      dat_o    <= '0;
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cyc_i && stb_i) begin
            state <= ST_RESP;
            ack_o <= d_ack;
            err_o <= d_err;
            dat_o <= d_dat;
            if (d_clear) begin
              ovf_flag <= 1'b0;
              unf_flag <= 1'b0;
            end
            if (d_ovf) ovf_flag <= 1'b1;
            if (d_unf) unf_flag <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          ack_o <= 1'b0;
          err_o <= 1'b0;
          dat_o <= '0;
        end
      endcase
    end
  end

  wb_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (req & d_push),
    .pop   (req & d_pop),
    .flush (req & d_flush),
    .wdata (dat_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_wb_fifo_slave.sv
// Directed bench for wb_fifo_slave: driver tasks push the expected reply
// into a queue, a negedge monitor pops and compares each ack/err pulse.
module tb_wb_fifo_slave;

  localparam int EW = 34;  // {ack, err, dat[31:0]}

  logic        clk;
  logic        rst_i;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [15:0] adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  wb_fifo_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (16),
    .DEPTH      (16)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .cyc_i     (cyc_i),
    .stb_i     (stb_i),
    .we_i      (we_i),
    .adr_i     (adr_i),
    .dat_i     (dat_i),
    .sel_i     (sel_i),
    .dat_o     (dat_o),
    .ack_o     (ack_o),
    .err_o     (err_o),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack/err pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst_i) begin
      if (ack_o || err_o) begin
        check("ack_err_exclusive", 64'(ack_o & err_o), 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'({ack_o, err_o, dat_o}), 64'd0);
        end else begin
          check("resp", 64'({ack_o, err_o, dat_o}), 64'(exp_q.pop_front()));
        end
      end else begin
        check("dat_zero_idle", 64'(dat_o), 64'd0);
      end
    end
  end

  // Driver: one request, called at posedge+1, returns at posedge+1 two cycles later
  task automatic op(input logic we, input logic [15:0] adr, input logic [31:0] wd,
                    input logic [3:0] sel, input logic e_ack, input logic [31:0] e_dat);
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i  = we;
    adr_i = adr;
    dat_i = wd;
    sel_i = sel;
    exp_q.push_back({e_ack, ~e_ack, e_dat});
    @(posedge clk);
    #1;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    @(posedge clk);
    #1;
    check("resp_seen", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wr(input logic [15:0] adr, input logic [31:0] wd, input logic e_ack);
    op(1'b1, adr, wd, 4'hF, e_ack, 32'h0);
  endtask

  task automatic rd(input logic [15:0] adr, input logic e_ack, input logic [31:0] e_dat);
    op(1'b0, adr, 32'h0, 4'hF, e_ack, e_dat);
  endtask

  task automatic status(input logic [31:0] e_dat);
    rd(16'h0004, 1'b1, e_dat);
  endtask

  initial begin
    rst_i = 1'b1;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    adr_i = '0;
    dat_i = '0;
    sel_i = '0;
    #2;
    check("rst_ack", 64'(ack_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_dat", 64'(dat_o), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    status(32'h0000_0001);

    // Basic push/pop ordering
    wr(16'h0000, 32'hA5A5_0001, 1'b1);
    wr(16'h0000, 32'hA5A5_0002, 1'b1);
    rd(16'h0000, 1'b1, 32'hA5A5_0001);
    rd(16'h0000, 1'b1, 32'hA5A5_0002);
    status(32'h0000_0001);

    // Underflow and sticky clear
    rd(16'h0000, 1'b0, 32'h0);
    status(32'h0000_0009);
    wr(16'h0008, 32'h2, 1'b1);
    status(32'h0000_0001);

    // Fill, overflow, flush keeps flags, clear drops them
    for (int i = 0; i < 16; i++) wr(16'h0000, 32'h100 + 32'(i), 1'b1);
    wr(16'h0000, 32'hDEAD_BEEF, 1'b0);
    status(32'h0000_1006);
    rd(16'h0000, 1'b1, 32'h0000_0100);
    status(32'h0000_0F04);
    wr(16'h0008, 32'h1, 1'b1);
    status(32'h0000_0005);
    wr(16'h0008, 32'h3, 1'b1);
    status(32'h0000_0001);

    // Pointer wrap-around
    for (int i = 0; i < 24; i++) begin
      wr(16'h0000, 32'(i), 1'b1);
      rd(16'h0000, 1'b1, 32'(i));
    end
    status(32'h0000_0001);

    // Flush, then error accesses leave count and flags alone
    for (int i = 0; i < 3; i++) wr(16'h0000, 32'h10 + 32'(i), 1'b1);
    status(32'h0000_0300);
    wr(16'h0008, 32'h1, 1'b1);
    status(32'h0000_0001);
    wr(16'h0000, 32'h55, 1'b1);
    status(32'h0000_0100);
    rd(16'h000C, 1'b0, 32'h0);
    wr(16'h000C, 32'h1, 1'b0);
    rd(16'h0002, 1'b0, 32'h0);
    op(1'b1, 16'h0000, 32'h66, 4'h3, 1'b0, 32'h0);
    wr(16'h0004, 32'hFFFF_FFFF, 1'b0);
    rd(16'h0008, 1'b1, 32'h0);
    status(32'h0000_0100);
    rd(16'h0000, 1'b1, 32'h55);
    status(32'h0000_0001);

    // cyc_i low: strobe ignored
    cyc_i = 1'b0;
    stb_i = 1'b1;
    we_i  = 1'b1;
    adr_i = 16'h0000;
    dat_i = 32'h1234;
    sel_i = 4'hF;
    repeat (4) @(posedge clk);
    #1;
    stb_i = 1'b0;
    status(32'h0000_0001);

    // Held strobe: one reply every second cycle
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i  = 1'b1;
    adr_i = 16'h0000;
    dat_i = 32'h77;
    sel_i = 4'hF;
    repeat (3) exp_q.push_back({1'b1, 1'b0, 32'h0});
    repeat (6) @(posedge clk);
    #1;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    @(posedge clk);
    #1;
    check("held_resp_count", 64'(exp_q.size()), 64'd0);
    status(32'h0000_0300);
    rd(16'h0000, 1'b1, 32'h77);

    // Reset during RESP drops the reply at once and empties the FIFO
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i  = 1'b1;
    dat_i = 32'h99;
    @(posedge clk);
    #1;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    check("resp_before_rst", 64'(ack_o), 64'd1);
    check("state_resp", 64'(dbg_state), 64'd1);
    rst_i = 1'b1;
    #1;
    check("ack_async_drop", 64'(ack_o), 64'd0);
    check("state_rst", 64'(dbg_state), 64'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    status(32'h0000_0001);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
